// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory, buffers returned words with their PC in a 2-entry queue
// and hands them to decode over valid/ready. A redirect flushes the queue.
// A request issued on the redirect edge itself is killed when its data returns.
// Optional build macro: IFETCH_PERF_CNT_EN adds fetch/flush performance counters.
module instr_fetch #(
  parameter int  ARCH_WIDTH   = 32,
  parameter int  RAM_DEPTH    = 4096,
  parameter int  RESET_VECTOR = 0,
  localparam int AW           = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [AW-1:0]         instr_addr_byte_out,
  input  logic [ARCH_WIDTH-1:0] instr_data_in,
  input  logic                  branch_en_in,
  input  logic [AW-1:0]         branch_addr_in,
  input  logic                  instr_ready_in,
  output logic                  instr_valid_out,
  output logic [ARCH_WIDTH-1:0] instr_out,
  output logic [AW-1:0]         pc_out,
  output logic                  misaligned_out
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt_out,
  output logic [31:0]           perf_flush_cnt_out
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         pc_q, pc_d;
  logic [AW-1:0]         req_pc_q, req_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  kill_q, kill_d;
  logic                  mis_q, mis_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ARCH_WIDTH-1:0] qdata_q [2];
  logic [ARCH_WIDTH-1:0] qdata_d [2];
  logic [AW-1:0]         qpc_q [2];
  logic [AW-1:0]         qpc_d [2];

  logic       pop;
  logic       push;
  logic [1:0] occ_left;
  logic       issue;

  // Handshake pop, queue push of returning data and occupancy left after the pop.
  assign pop      = (cnt_q != 2'd0) && instr_ready_in;
  assign push     = inflight_q && !kill_q;
  assign occ_left = cnt_q - {1'b0, pop};

  // Next-state logic: FSM, issue rule, queue update and redirect handling.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    kill_d     = kill_q;
    mis_d      = 1'b0;
    cnt_d      = cnt_q;
    qdata_d    = qdata_q;
    qpc_d      = qpc_q;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        // Queue slots left after this pop plus the outstanding request bound issue.
        issue      = ({1'b0, occ_left} + {2'b00, inflight_q}) < 3'd2;
        inflight_d = issue;
        if (inflight_q) kill_d = 1'b0;
        if (issue) req_pc_d = pc_q;
        if (branch_en_in) begin
          // The address sampled on this edge is stale; kill its data if it was issued.
          cnt_d  = 2'd0;
          kill_d = issue;
          pc_d   = {branch_addr_in[AW-1:2], 2'b00};
          mis_d  = |branch_addr_in[1:0];
        end else begin
          if (issue) pc_d = pc_q + AW'(4);
          if (pop) begin
            qdata_d[0] = qdata_q[1];
            qpc_d[0]   = qpc_q[1];
          end
          if (push) begin
            if (occ_left == 2'd0) begin
              qdata_d[0] = instr_data_in;
              qpc_d[0]   = req_pc_q;
            end else begin
              qdata_d[1] = instr_data_in;
              qpc_d[1]   = req_pc_q;
            end
          end
          cnt_d = occ_left + {1'b0, push};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset returns to IDLE with an empty queue at the reset vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= AW'(RESET_VECTOR);
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      mis_q      <= 1'b0;
      cnt_q      <= 2'd0;
      qdata_q[0] <= '0;
      qdata_q[1] <= '0;
      qpc_q[0]   <= '0;
      qpc_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
      qdata_q    <= qdata_d;
      qpc_q      <= qpc_d;
    end
  end

  assign instr_addr_byte_out = pc_q;
  assign instr_valid_out     = (cnt_q != 2'd0);
  assign instr_out           = qdata_q[0];
  assign pc_out              = qpc_q[0];
  assign misaligned_out      = mis_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [1:0]  flush_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + 33'(inc);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Discarded words: surviving queue entries plus the returning word on a
  // redirect, otherwise a killed return.
  always_comb begin
    flush_inc = 2'd0;
    if (state_q == RUN && branch_en_in) flush_inc = occ_left + {1'b0, inflight_q};
    else if (kill_q && inflight_q)      flush_inc = 2'd1;
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= sat_add(fetch_cnt_q, {1'b0, pop});
      flush_cnt_q <= sat_add(flush_cnt_q, flush_inc);
    end
  end

  assign perf_fetch_cnt_out = fetch_cnt_q;
  assign perf_flush_cnt_out = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: stream, stall, redirect, misaligned
// redirect, address wrap, back-to-back redirect and mid-stream reset.
module tb_instr_fetch;
  localparam int RAM_DEPTH = 4096;
  localparam int AW        = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] instr_addr_byte_out;
  logic [31:0]   instr_data_in;
  logic          branch_en_in;
  logic [AW-1:0] branch_addr_in;
  logic          instr_ready_in;
  logic          instr_valid_out;
  logic [31:0]   instr_out;
  logic [AW-1:0] pc_out;
  logic          misaligned_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:RAM_DEPTH/4-1];

  instr_fetch #(.ARCH_WIDTH(32), .RAM_DEPTH(RAM_DEPTH), .RESET_VECTOR(0)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instr_addr_byte_out (instr_addr_byte_out),
    .instr_data_in       (instr_data_in),
    .branch_en_in        (branch_en_in),
    .branch_addr_in      (branch_addr_in),
    .instr_ready_in      (instr_ready_in),
    .instr_valid_out     (instr_valid_out),
    .instr_out           (instr_out),
    .pc_out              (pc_out),
    .misaligned_out      (misaligned_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory, word i holds value i.
  always @(posedge clk) instr_data_in <= mem[instr_addr_byte_out[AW-1:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, then release just after an edge.
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; branch_en_in = 1'b0; branch_addr_in = '0; instr_ready_in = 1'b1;
    step();
    step();
    checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", instr_valid_out); end
    checks++; if (instr_out !== 32'd0) begin errors++; $display("FAIL reset_instr got=%0h exp=0", instr_out); end
    checks++; if (pc_out !== 12'd0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", pc_out); end
    checks++; if (misaligned_out !== 1'b0) begin errors++; $display("FAIL reset_mis got=%0b exp=0", misaligned_out); end
    checks++; if (instr_addr_byte_out !== 12'd0) begin errors++; $display("FAIL reset_addr got=%0h exp=0", instr_addr_byte_out); end
  endtask

  // First edge after release goes IDLE->RUN, second issues address 0,
  // third delivers word 0; then one word per cycle.
  task automatic check_startup(input string tag);
    step();
    checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL %s_e1_valid got=%0b exp=0", tag, instr_valid_out); end
    step();
    checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL %s_e2_valid got=%0b exp=0", tag, instr_valid_out); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (instr_valid_out !== 1'b1 || pc_out !== 12'(4*k) || instr_out !== 32'(k)) begin
        errors++;
        $display("FAIL %s_word%0d got v=%0b pc=%0h d=%0h exp v=1 pc=%0h d=%0h", tag, k, instr_valid_out, pc_out, instr_out, 4*k, k);
      end
    end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    check_startup("stream");
  endtask

  task automatic test_stall();
    do_reset();
    instr_ready_in = 1'b1;
    step();
    step();
    step();
    instr_ready_in = 1'b0;
    checks++; if (instr_valid_out !== 1'b1 || pc_out !== 12'd0) begin errors++; $display("FAIL stall_first got v=%0b pc=%0h exp v=1 pc=0", instr_valid_out, pc_out); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (instr_valid_out !== 1'b1 || pc_out !== 12'd0 || instr_out !== 32'd0 || instr_addr_byte_out !== 12'd8) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%0b pc=%0h d=%0h addr=%0h exp v=1 pc=0 d=0 addr=8", c, instr_valid_out, pc_out, instr_out, instr_addr_byte_out);
      end
    end
    instr_ready_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (instr_valid_out !== 1'b1 || pc_out !== 12'(4*k) || instr_out !== 32'(k)) begin
        errors++;
        $display("FAIL stall_resume%0d got v=%0b pc=%0h d=%0h exp v=1 pc=%0h d=%0h", k, instr_valid_out, pc_out, instr_out, 4*k, k);
      end
    end
  endtask

  // Redirect at a steady stream; expect two empty cycles then the target stream.
  task automatic run_redirect(input string tag, input logic [AW-1:0] tgt, input logic exp_mis,
                              input logic [AW-1:0] pc0, input logic [AW-1:0] pc1);
    do_reset();
    instr_ready_in = 1'b1;
    for (int c = 0; c < 5; c++) step();
    branch_en_in = 1'b1; branch_addr_in = tgt;
    step();
    branch_en_in = 1'b0; branch_addr_in = '0;
    checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL %s_flush1 got v=%0b pc=%0h exp v=0", tag, instr_valid_out, pc_out); end
    checks++; if (misaligned_out !== exp_mis) begin errors++; $display("FAIL %s_mis got=%0b exp=%0b", tag, misaligned_out, exp_mis); end
    step();
    checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL %s_flush2 got v=%0b pc=%0h exp v=0", tag, instr_valid_out, pc_out); end
    checks++; if (misaligned_out !== 1'b0) begin errors++; $display("FAIL %s_mis_clear got=%0b exp=0", tag, misaligned_out); end
    step();
    checks++;
    if (instr_valid_out !== 1'b1 || pc_out !== pc0 || instr_out !== 32'(pc0 >> 2)) begin
      errors++;
      $display("FAIL %s_target got v=%0b pc=%0h d=%0h exp v=1 pc=%0h d=%0h", tag, instr_valid_out, pc_out, instr_out, pc0, pc0 >> 2);
    end
    step();
    checks++;
    if (instr_valid_out !== 1'b1 || pc_out !== pc1 || instr_out !== 32'(pc1 >> 2)) begin
      errors++;
      $display("FAIL %s_next got v=%0b pc=%0h d=%0h exp v=1 pc=%0h d=%0h", tag, instr_valid_out, pc_out, instr_out, pc1, pc1 >> 2);
    end
  endtask

  task automatic test_redirect();
    run_redirect("redirect", 12'h040, 1'b0, 12'h040, 12'h044);
  endtask

  task automatic test_misaligned();
    run_redirect("misalign", 12'h042, 1'b1, 12'h040, 12'h044);
  endtask

  task automatic test_wrap();
    run_redirect("wrap", 12'(RAM_DEPTH-4), 1'b0, 12'(RAM_DEPTH-4), 12'h000);
  endtask

  task automatic test_back_to_back();
    do_reset();
    instr_ready_in = 1'b1;
    for (int c = 0; c < 5; c++) step();
    branch_en_in = 1'b1; branch_addr_in = 12'h100;
    step();
    branch_addr_in = 12'h200;
    step();
    branch_en_in = 1'b0; branch_addr_in = '0;
    checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_flush1 got v=%0b pc=%0h exp v=0", instr_valid_out, pc_out); end
    step();
    checks++; if (instr_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_flush2 got v=%0b pc=%0h exp v=0", instr_valid_out, pc_out); end
    step();
    checks++;
    if (instr_valid_out !== 1'b1 || pc_out !== 12'h200 || instr_out !== 32'h80) begin
      errors++;
      $display("FAIL b2b_target got v=%0b pc=%0h d=%0h exp v=1 pc=200 d=80", instr_valid_out, pc_out, instr_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr_ready_in = 1'b0;
    for (int c = 0; c < 6; c++) step();
    checks++; if (instr_valid_out !== 1'b1 || instr_addr_byte_out !== 12'd8) begin errors++; $display("FAIL rstmid_full got v=%0b addr=%0h exp v=1 addr=8", instr_valid_out, instr_addr_byte_out); end
    rst = 1'b1;
    #1;
    checks++;
    if (instr_valid_out !== 1'b0 || instr_out !== 32'd0 || pc_out !== 12'd0 || instr_addr_byte_out !== 12'd0 || misaligned_out !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got v=%0b d=%0h pc=%0h addr=%0h mis=%0b exp all 0", instr_valid_out, instr_out, pc_out, instr_addr_byte_out, misaligned_out);
    end
    step();
    step();
    rst = 1'b0;
    instr_ready_in = 1'b1;
    check_startup("rstmid");
  endtask

  initial begin
    for (int i = 0; i < RAM_DEPTH/4; i++) mem[i] = 32'(i);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
